// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths: FSM encoding,
// frame shape and the cycles-per-bit helper macro.
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define SYMBOL_EDGE_TIME(clock, baud) ((clock) / (baud))

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

`endif

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts cycles since it was last cleared and strobes when the
// count equals the programmed terminal value, wrapping back to zero on the strobe.
module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             sample_strobe
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        sample_strobe = (count_q == terminal);
        if (clear || sample_strobe) begin
            count_d = '0;
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path (8N1, LSB first, idle-high) with ready/valid byte output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME    = `SYMBOL_EDGE_TIME(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_TERM = CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] FULL_TERM = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]                     LAST_BIT  = 3'(DATA_BITS - 1);

    generate
        if (SYMBOL_EDGE_TIME < 4 || STOP_BITS != 1) begin : g_bad_config
            $error("uart_receiver: need >= 4 clocks per bit and exactly one stop bit");
        end
    endgenerate

    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        framing_error_q, framing_error_d;
    logic        overrun_q, overrun_d;
    logic        sync1_q, sync2_q;
    logic        rx_s;

    logic                           timer_clear;
    logic [CLOCK_COUNTER_WIDTH-1:0] timer_terminal;
    logic                           strobe;
    logic                           take_sample;
    logic                           sample_bit;
    logic                           fire;
    logic                           frame_good;

    assign rx_s           = sync2_q;
    assign fire           = valid_q && data_out_ready;
    assign timer_clear    = (state_q == IDLE);
    assign timer_terminal = (state_q == START) ? HALF_TERM : FULL_TERM;

    uart_bit_timer #(
        .WIDTH(CLOCK_COUNTER_WIDTH)
    ) u_bit_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (timer_clear),
        .terminal     (timer_terminal),
        .sample_strobe(strobe)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decide one cycle after the strobe, voting over strobe-1, strobe and strobe+1.
    logic rx_d1_q, rx_d2_q, strobe_q;
    assign take_sample = strobe_q;
    assign sample_bit  = (rx_d2_q & rx_d1_q) | (rx_d2_q & rx_s) | (rx_d1_q & rx_s);
`else
    assign take_sample = strobe;
    assign sample_bit  = rx_s;
`endif

    always_comb begin
        state_d         = state_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        data_d          = data_q;
        valid_d         = valid_q;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;
        frame_good      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (take_sample) begin
                    state_d   = sample_bit ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (take_sample) begin
                    shift_d[bit_idx_q] = sample_bit;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
                if (take_sample) begin
                    state_d         = IDLE;
                    frame_good      = sample_bit;
                    framing_error_d = !sample_bit;
                end
            end
        endcase

        if (frame_good) begin
            if (!valid_q || fire) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            valid_q         <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            rx_d1_q         <= 1'b1;
            rx_d2_q         <= 1'b1;
            strobe_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
            sync1_q         <= serial_in;
            sync2_q         <= sync1_q;
`ifdef UART_RX_MAJORITY_EN
            rx_d1_q         <= rx_s;
            rx_d2_q         <= rx_d1_q;
            strobe_q        <= strobe && (state_q != IDLE);
`endif
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = framing_error_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 10 clocks per bit, with a frame-level
// reference model compared against the DUT outputs every cycle.
module tb_uart_receiver;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int SET        = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME_LEN  = 10 * SET;
`ifdef UART_RX_MAJORITY_EN
    localparam int LATENCY    = (19 * SET) / 2 + 3 + 1;
`else
    localparam int LATENCY    = (19 * SET) / 2 + 3;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    uart_receiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       good;
        logic [7:0] data;
    } frame_ev_t;

    frame_ev_t  evq[$];
    logic [7:0] accepted[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         win_valid, win_fe, win_ov;

    logic       m_valid, m_fe, m_ov;
    logic [7:0] m_data;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Frame-level model: a frame completes LATENCY cycles after its start bit is
    // driven, then the holding-register rules decide load, overrun or discard.
    always @(posedge clk) begin
        logic fire;
        cyc++;
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
            evq.delete();
        end else begin
            fire = m_valid && data_out_ready;
            m_fe = 1'b0;
            m_ov = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                frame_ev_t ev;
                ev = evq.pop_front();
                if (ev.good) begin
                    if (!m_valid || fire) begin
                        m_data  = ev.data;
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else begin
                    m_fe = 1'b1;
                    if (fire) m_valid = 1'b0;
                end
            end else if (fire) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("data_out_valid", {31'd0, data_out_valid}, {31'd0, m_valid});
            if (m_valid) checkOutput("data_out", {24'd0, data_out}, {24'd0, m_data});
            checkOutput("framing_error", {31'd0, framing_error}, {31'd0, m_fe});
            checkOutput("overrun", {31'd0, overrun}, {31'd0, m_ov});
            if (data_out_valid === 1'b1) win_valid++;
            if (framing_error === 1'b1) win_fe++;
            if (overrun === 1'b1) win_ov++;
            if (reset_n && data_out_valid === 1'b1 && data_out_ready) accepted.push_back(data_out);
        end
    end

    task automatic idleLine(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearWindow();
        win_valid = 0;
        win_fe    = 0;
        win_ov    = 0;
    endtask

    // Sends one frame; glitch_at inverts the line for one cycle at that offset,
    // reset_at pulses reset_n low for one cycle there and abandons the frame.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                 input int glitch_at, input int reset_at);
        logic level;
        evq.push_back('{cyc: cyc + LATENCY, good: stop_bit, data: b});
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k < SET) level = 1'b0;
            else if (k < 9 * SET) level = b[(k - SET) / SET];
            else level = stop_bit;
            if (k == glitch_at) level = ~level;
            serial_in = level;
            if (k == reset_at) begin
                reset_n = 1'b0;
                @(posedge clk);
                #1;
                reset_n   = 1'b1;
                serial_in = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        serial_in = 1'b1;
    endtask

    initial begin
        logic [7:0] expected_bytes[$];
        serial_in      = 1'b1;
        reset_n        = 1'b0;
        data_out_ready = 1'b1;
        clearWindow();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset data_out", {24'd0, data_out}, 32'h00);
        checkOutput("reset valid", {31'd0, data_out_valid}, 32'd0);
        checkOutput("reset framing_error", {31'd0, framing_error}, 32'd0);
        checkOutput("reset overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        idleLine(20);

        $display("[TB] byte A5 with ready high");
        clearWindow();
        applyStimulus(8'hA5, 1'b1, -1, -1);
        idleLine(20);
        checkOutput("A5 valid cycles", win_valid, 32'd1);
        checkOutput("A5 error pulses", win_fe + win_ov, 32'd0);

        $display("[TB] 3-cycle glitch on idle line");
        clearWindow();
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idleLine(30);
        checkOutput("glitch valid cycles", win_valid, 32'd0);
        checkOutput("glitch framing pulses", win_fe, 32'd0);

`ifdef UART_RX_MAJORITY_EN
        $display("[TB] byte 3C with 1-cycle glitch mid bit 2");
        clearWindow();
        applyStimulus(8'h3C, 1'b1, 3 * SET + SET / 2, -1);
        idleLine(20);
        checkOutput("3C glitch valid cycles", win_valid, 32'd1);
`endif

        $display("[TB] byte 3C with stop bit low, then 01");
        clearWindow();
        applyStimulus(8'h3C, 1'b0, -1, -1);
        idleLine(20);
        checkOutput("3C framing pulses", win_fe, 32'd1);
        checkOutput("3C valid cycles", win_valid, 32'd0);
        clearWindow();
        applyStimulus(8'h01, 1'b1, -1, -1);
        idleLine(20);
        checkOutput("01 valid cycles", win_valid, 32'd1);

        $display("[TB] bytes 11 and 22 back-to-back with ready low");
        clearWindow();
        data_out_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, -1, -1);
        applyStimulus(8'h22, 1'b1, -1, -1);
        idleLine(20);
        checkOutput("overrun pulses", win_ov, 32'd1);
        checkOutput("held data_out", {24'd0, data_out}, 32'h11);
        checkOutput("held valid", {31'd0, data_out_valid}, 32'd1);
        data_out_ready = 1'b1;
        idleLine(10);

        $display("[TB] bytes 00 and FF back-to-back with ready high");
        clearWindow();
        applyStimulus(8'h00, 1'b1, -1, -1);
        applyStimulus(8'hFF, 1'b1, -1, -1);
        idleLine(20);
        checkOutput("00/FF valid cycles", win_valid, 32'd2);

        $display("[TB] reset during bit 4 of 55, then C3");
        clearWindow();
        applyStimulus(8'h55, 1'b1, -1, 5 * SET + SET / 2);
        idleLine(LATENCY + 20);
        checkOutput("aborted valid cycles", win_valid, 32'd0);
        checkOutput("aborted framing pulses", win_fe, 32'd0);
        clearWindow();
        applyStimulus(8'hC3, 1'b1, -1, -1);
        idleLine(20);
        checkOutput("C3 valid cycles", win_valid, 32'd1);

`ifdef UART_RX_MAJORITY_EN
        expected_bytes = '{8'hA5, 8'h3C, 8'h01, 8'h11, 8'h00, 8'hFF, 8'hC3};
`else
        expected_bytes = '{8'hA5, 8'h01, 8'h11, 8'h00, 8'hFF, 8'hC3};
`endif
        checkOutput("accepted count", accepted.size(), expected_bytes.size());
        for (int i = 0; i < expected_bytes.size(); i++) begin
            if (i < accepted.size()) begin
                checkOutput($sformatf("accepted[%0d]", i), {24'd0, accepted[i]}, {24'd0, expected_bytes[i]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
